// File: rtl/vram_arbiter.sv
// Shares split VRAM between the VDP (absolute priority on DLClk slots) and one
// auxiliary requester whose accesses are posted through a small FIFO.
module vram_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        vdp_slot,
    input  logic [16:0] vdp_addr,
    input  logic [7:0]  vdp_wdata,
    input  logic        vdp_we,
    output logic [15:0] vdp_rdata,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [16:0] aux_addr,
    input  logic [7:0]  aux_wdata,
    output logic        aux_ready,
    output logic        aux_rvalid,
    output logic [7:0]  aux_rdata,
    output logic        busy,
    output logic        timeout,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we_lo,
    output logic        mem_we_hi,
    input  logic [7:0]  mem_q_lo,
    input  logic [7:0]  mem_q_hi
);

    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);

    // Entry layout: {we, addr[16:0], wdata[7:0]}
    logic [25:0]   fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          read_pending_q, rd_issue_q, rd_bank_q, vdp_cycle_q, timeout_q;
    logic [15:0]   starve_q, starve_d;
    logic [15:0]   vdp_rdata_q;
    logic [7:0]    aux_rdata_q;

    logic          port_en, empty, full, push, issue;
    logic [25:0]   head;
    logic [7:0]    rd_sel;

    always_comb begin
        // Reset also forces the port idle, not just the registered state.
        port_en   = enable & reset_n;
        empty     = (count_q == '0);
        full      = (count_q == FULL_COUNT);
        aux_ready = port_en & ~full & ~read_pending_q;
        push      = aux_req & aux_ready;
        head      = fifo_q[rd_ptr_q];
        issue     = port_en & ~vdp_slot & ~empty;
        rd_sel    = rd_bank_q ? mem_q_hi : mem_q_lo;
    end

    always_comb begin
        mem_addr  = 16'hFFFF;
        mem_data  = 8'hFF;
        mem_we_lo = 1'b0;
        mem_we_hi = 1'b0;
        if (port_en && vdp_slot) begin
            mem_addr  = vdp_addr[15:0];
            mem_data  = vdp_wdata;
            mem_we_lo = vdp_we & ~vdp_addr[16];
            mem_we_hi = vdp_we & vdp_addr[16];
        end else if (issue) begin
            mem_addr  = head[23:8];
            mem_data  = head[7:0];
            mem_we_lo = head[25] & ~head[24];
            mem_we_hi = head[25] & head[24];
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (issue) begin
            starve_d = '0;
        end else if (enable && !empty && starve_q != TIMEOUT_C) begin
            starve_d = starve_q + 16'd1;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {aux_we, aux_addr, aux_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            read_pending_q <= 1'b0;
            rd_issue_q     <= 1'b0;
            rd_bank_q      <= 1'b0;
            vdp_cycle_q    <= 1'b0;
            timeout_q      <= 1'b0;
            starve_q       <= '0;
            vdp_rdata_q    <= '0;
            aux_rdata_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (issue) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_bank_q <= head[24];
            end
            if (push && !issue) begin
                count_q <= count_q + 1'b1;
            end else if (!push && issue) begin
                count_q <= count_q - 1'b1;
            end
            if (push && !aux_we) begin
                read_pending_q <= 1'b1;
            end else if (rd_issue_q) begin
                read_pending_q <= 1'b0;
            end
            rd_issue_q  <= issue & ~head[25];
            vdp_cycle_q <= port_en & vdp_slot;
            if (vdp_cycle_q) begin
                vdp_rdata_q <= {mem_q_hi, mem_q_lo};
            end
            if (rd_issue_q) begin
                aux_rdata_q <= rd_sel;
            end
            starve_q  <= starve_d;
            timeout_q <= timeout_q | (starve_d == TIMEOUT_C);
        end
    end

    // Read data is shown combinationally in the completion cycle, then held.
    assign aux_rvalid = rd_issue_q;
    assign aux_rdata  = rd_issue_q ? rd_sel : aux_rdata_q;
    assign vdp_rdata  = vdp_rdata_q;
    assign busy       = ~empty | read_pending_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: scoreboarded aux writes/reads against a
// registered-output memory model, plus priority, full, starvation and reset steps.
module tb_vram_arbiter;

    logic        clk, reset_n, enable, vdp_slot, vdp_we, aux_req, aux_we;
    logic [16:0] vdp_addr, aux_addr;
    logic [7:0]  vdp_wdata, aux_wdata, aux_rdata, mem_data, mem_q_lo, mem_q_hi;
    logic [15:0] vdp_rdata, mem_addr;
    logic        aux_ready, aux_rvalid, busy, timeout, mem_we_lo, mem_we_hi;

    int checks = 0;
    int failures = 0;
    int rv_count = 0;
    bit toggle = 0;

    logic [24:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  mem [131072];
    logic [7:0]  sh [131072];

    vram_arbiter #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .vdp_slot(vdp_slot),
        .vdp_addr(vdp_addr), .vdp_wdata(vdp_wdata), .vdp_we(vdp_we), .vdp_rdata(vdp_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ready(aux_ready), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .busy(busy), .timeout(timeout), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi), .mem_q_lo(mem_q_lo), .mem_q_hi(mem_q_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: address in cycle N gives data in cycle N+1.
    always @(posedge clk) begin
        if (mem_we_lo) mem[{1'b0, mem_addr}] <= mem_data;
        if (mem_we_hi) mem[{1'b1, mem_addr}] <= mem_data;
        mem_q_lo <= mem[{1'b0, mem_addr}];
        mem_q_hi <= mem[{1'b1, mem_addr}];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && !vdp_slot && (mem_we_lo || mem_we_hi)) begin
            chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) chk("write_order", {mem_we_hi, mem_addr, mem_data},
                                        exp_wr.pop_front());
        end
        if (aux_rvalid) begin
            rv_count++;
            chk("read_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) chk("aux_rdata", aux_rdata, exp_rd.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle) vdp_slot = ~vdp_slot;
    endtask

    task automatic push(input logic we, input logic [16:0] addr, input logic [7:0] data);
        bit done = 0;
        aux_req = 1'b1; aux_we = we; aux_addr = addr; aux_wdata = data;
        for (int i = 0; i < 50 && !done; i++) begin
            if (aux_ready) begin
                if (we) begin
                    exp_wr.push_back({addr, data});
                    sh[addr] = data;
                end else begin
                    exp_rd.push_back(sh[addr]);
                end
                done = 1;
            end
            tick();
        end
        aux_req = 1'b0;
        chk("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic vdp_cycle(input logic we, input logic [16:0] addr, input logic [7:0] data);
        vdp_slot = 1'b1; vdp_we = we; vdp_addr = addr; vdp_wdata = data;
        if (we) sh[addr] = data;
        tick();
        vdp_slot = 1'b0; vdp_we = 1'b0;
    endtask

    task automatic wait_rvalid();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (aux_rvalid) seen = 1;
            else begin
                chk("ready_while_pending", 32'(aux_ready), 32'd0);
                tick();
            end
        end
        chk("rvalid_seen", 32'(seen), 32'd1);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && busy; i++) tick();
        chk("drained", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; vdp_slot = 1'b1; vdp_we = 1'b1;
        vdp_addr = 17'h12345; vdp_wdata = 8'hA5;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
        #3;
        chk("rst_mem_addr", mem_addr, 16'hFFFF);
        chk("rst_mem_data", mem_data, 8'hFF);
        chk("rst_we", {mem_we_hi, mem_we_lo}, 2'b00);
        chk("rst_ready", aux_ready, 0);
        chk("rst_flags", {busy, timeout, aux_rvalid}, 3'b000);
        chk("rst_rdata", {vdp_rdata, aux_rdata}, 24'h0);
        vdp_slot = 1'b0; vdp_we = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("ready_after_reset", aux_ready, 1);

        // Preload through the VDP write path.
        vdp_cycle(1'b1, 17'h00010, 8'h77);
        vdp_cycle(1'b1, 17'h10010, 8'h99);

        // VDP priority over a pending aux write.
        vdp_slot = 1'b1;
        push(1'b1, 17'h00200, 8'h11);
        vdp_we = 1'b1; vdp_addr = 17'h12345; vdp_wdata = 8'hA5; sh[17'h12345] = 8'hA5;
        #1;
        chk("vdp_we", {mem_we_hi, mem_we_lo}, 2'b10);
        chk("vdp_addr", mem_addr, 16'h2345);
        chk("vdp_data", mem_data, 8'hA5);
        chk("vdp_busy", busy, 1);
        tick();
        vdp_slot = 1'b0; vdp_we = 1'b0;
        #1;
        chk("aux_after_slot", {mem_we_hi, mem_we_lo, mem_addr, mem_data}, {2'b01, 16'h0200, 8'h11});
        tick();
        chk("prio_idle", busy, 0);

        // Ordering with DLClk toggling every cycle.
        toggle = 1;
        push(1'b1, 17'h00100, 8'h3C);
        push(1'b0, 17'h00100, 8'h00);
        wait_rvalid();
        toggle = 0; vdp_slot = 1'b0;
        tick(); tick();
        chk("single_rvalid", rv_count, 1);

        // Enable dropped with a queued entry.
        vdp_slot = 1'b1;
        push(1'b1, 17'h00300, 8'h5A);
        enable = 1'b0; vdp_slot = 1'b0;
        tick(); tick(); tick();
        chk("dis_port", {mem_we_hi, mem_we_lo, mem_addr}, {2'b00, 16'hFFFF});
        chk("dis_busy_ready", {busy, aux_ready}, 2'b10);
        enable = 1'b1;
        #1;
        chk("resume_addr", mem_addr, 16'h0300);
        drain();

        // FIFO full, then wrap with continuous traffic.
        vdp_slot = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, {i[0], 16'h4000 + 16'(i)}, 8'(i * 7 + 1));
        chk("full_ready", aux_ready, 0);
        vdp_slot = 1'b0;
        for (int i = 4; i < 14; i++) push(1'b1, {i[0], 16'h4000 + 16'(i)}, 8'(i * 7 + 1));
        drain();
        chk("all_writes_seen", exp_wr.size(), 0);

        // Starvation.
        chk("timeout_clear", timeout, 0);
        vdp_slot = 1'b1;
        push(1'b1, 17'h00400, 8'hC3);
        repeat (7) tick();
        chk("timeout_at_7", timeout, 0);
        tick();
        chk("timeout_at_8", timeout, 1);
        vdp_slot = 1'b0;
        drain();
        chk("timeout_sticky", timeout, 1);

        // VDP read isolation.
        vdp_cycle(1'b0, 17'h00010, 8'h00);
        push(1'b0, 17'h10010, 8'h00);
        chk("vdp_rdata", vdp_rdata, 16'h9977);
        wait_rvalid();
        chk("vdp_rdata_hold", vdp_rdata, 16'h9977);
        push(1'b1, 17'h00030, 8'h12);
        push(1'b0, 17'h00030, 8'h00);
        wait_rvalid();
        drain();
        chk("vdp_rdata_hold2", vdp_rdata, 16'h9977);

        // Reset mid-stream with three entries queued.
        vdp_slot = 1'b1;
        push(1'b1, 17'h00500, 8'h01);
        push(1'b1, 17'h00501, 8'h02);
        push(1'b1, 17'h00502, 8'h03);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_port", {mem_we_hi, mem_we_lo, mem_addr}, {2'b00, 16'hFFFF});
        chk("mid_rst_ready_timeout", {aux_ready, timeout}, 2'b00);
        exp_wr.delete();
        vdp_slot = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", aux_ready, 1);

        chk("reads_done", exp_rd.size(), 0);
        chk("rvalid_total", rv_count, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the 128 KB split VRAM (two 64 KB banks, `lo`/`hi`) between the VDP and one auxiliary requester, such as a debug/save-state loader or a DMA engine. The VDP has absolute priority: it owns every memory cycle flagged by its slot strobe (DLClk) with zero added latency. Auxiliary accesses are queued in a posted FIFO and issued only in non-VDP cycles. The block sits between the VDP core and `vram_bus`, replacing the direct write-enable gating.

## Interface
- `FIFO_DEPTH`, 4, aux request FIFO entries; power of two, 2..16
- `TIMEOUT`, 255, consecutive starved cycles before `timeout` sets; 1..65535

- `clk`  in  1  system clock (CLK21M domain)
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  device enable; 0 idles the memory port
- `vdp_slot`  in  1  VDP owns the current cycle (DLClk)
- `vdp_addr`  in  17  VDP address; bit 16 selects the bank
- `vdp_wdata`  in  8  VDP write data
- `vdp_we`  in  1  VDP write, active high, qualified by `vdp_slot`
- `vdp_rdata`  out  16  registered `{mem_q_hi, mem_q_lo}` from the last VDP cycle
- `aux_req`  in  1  aux request valid
- `aux_we`  in  1  1 = write, 0 = read
- `aux_addr`  in  17  aux address
- `aux_wdata`  in  8  aux write data
- `aux_ready`  out  1  request accepted when `aux_req & aux_ready` at a rising edge
- `aux_rvalid`  out  1  one-cycle pulse; `aux_rdata` is valid
- `aux_rdata`  out  8  read data, bank-selected
- `busy`  out  1  FIFO non-empty or read pending
- `timeout`  out  1  sticky starvation flag
- `mem_addr`  out  16  to `vram_bus.addr`
- `mem_data`  out  8  to `vram_bus.data`
- `mem_we_lo`, `mem_we_hi`  out  1  bank write enables
- `mem_q_lo`, `mem_q_hi`  in  8  memory read data; address in cycle N gives data in cycle N+1

## Operation
- **Reset** (`reset_n` = 0, asynchronous):
  - FIFO is emptied; `read_pending`, the read-capture flag and the starvation counter are cleared.
  - `vdp_rdata` = 0, `aux_rdata` = 0; `aux_rvalid`, `aux_ready`, `busy` and `timeout` = 0.
  - Memory port is forced idle: `mem_addr` = FFFF, `mem_data` = FF, both write enables = 0.
- **Cycle ownership** (combinational mux):
  - `enable` = 0: memory port idle (values as in reset); `aux_ready` = 0.
  - `vdp_slot` = 1: VDP drives the port.
    - `mem_addr` = `vdp_addr[15:0]`, `mem_data` = `vdp_wdata`.
    - `mem_we_lo` = `vdp_we & ~vdp_addr[16]`, `mem_we_hi` = `vdp_we & vdp_addr[16]`.
  - `vdp_slot` = 0 and FIFO non-empty: the FIFO head drives the port.
    - Write enables follow the head's `we` and bank bit.
    - The head is popped at the clock edge ending the cycle.
  - Otherwise: port idle.
- **VDP read path:** `vdp_rdata` loads `{mem_q_hi, mem_q_lo}` in the cycle after each VDP-owned cycle and holds at all other times, so aux cycles never disturb VDP read data.
- **Aux FIFO:**
  - Entry format: `{we, addr[16:0], wdata[7:0]}`.
  - `aux_ready` = `enable & ~full & ~read_pending`.
  - An accepted write is posted and needs no completion signal.
  - An accepted read sets `read_pending`, which blocks further requests until its `aux_rvalid`.
  - FIFO order is preserved, so a read observes all earlier writes.
  - Simultaneous push and pop in one cycle leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. Full/empty are decided by a count of width log2(`FIFO_DEPTH`)+1.
- **Read completion:**
  - When a read entry issues, its `addr[16]` is registered.
  - In the next cycle `aux_rdata` = `addr[16] ? mem_q_hi : mem_q_lo` and `aux_rvalid` = 1; `read_pending` clears on the same edge.
  - This holds even if that next cycle is VDP-owned or has `enable` = 0.
- **Starvation counter:**
  - Increments on each cycle with `enable` = 1, FIFO non-empty and no issue (blocked by `vdp_slot`).
  - Clears on each issue and saturates at `TIMEOUT`.
  - Reaching `TIMEOUT` sets `timeout`, which stays set until reset.
- `busy` = FIFO non-empty | `read_pending`.
- **`enable` dropped mid-operation:** FIFO contents are retained and nothing issues. Operation resumes unchanged when `enable` returns.

## Timing
- VDP path has zero latency; `vdp_rdata` updates one edge after the VDP cycle's data appears.
- Aux write accepted at edge E: earliest issue is cycle E+1, if `vdp_slot` = 0 and the FIFO holds no older entries.
- Aux read accepted at edge E with an empty FIFO: issue in the first non-slot cycle ≥ E+1; `aux_rvalid` one cycle after issue (minimum 2 cycles after acceptance).
- Throughput: one aux access per non-VDP cycle. With DLClk at 50% duty this is ≤ clk/2.
- `aux_ready` reflects the state registered at the previous edge; it drops the cycle after a read is accepted or the FIFO fills.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-stream with 3 FIFO entries → `busy` = 0, `mem_addr` = FFFF, write enables = 0, `aux_ready` = 0 while in reset; FIFO empty after release.
- **VDP priority:** `vdp_slot` = 1, `vdp_we` = 1, `vdp_addr` = 1_2345, `vdp_wdata` = A5 with an aux write pending → `mem_we_hi` = 1, `mem_addr` = 2345, `mem_data` = A5; aux issues only in the next `vdp_slot` = 0 cycle.
- **Ordering:**
  - Sequence: aux write 0_0100 = 3C, then aux read 0_0100, with `vdp_slot` toggling every cycle.
  - Required: write issues before the read, `aux_rdata` = 3C with a single `aux_rvalid` pulse, and `aux_ready` = 0 between read accept and `aux_rvalid`.
- **FIFO full/wrap:**
  - Push 4 writes with `vdp_slot` held at 1, so nothing drains.
  - Required after the 4th push: `aux_ready` = 0.
  - Release `vdp_slot`, then issue 10 further writes.
  - Required: all 14 writes reach memory in order.
- **Starvation:** `TIMEOUT` = 8, one entry queued, `vdp_slot` held at 1 for 8 cycles → `timeout` = 1 and it stays 1 after the entry drains.
- **VDP read isolation:**
  - Sequence: VDP read of 0_0010 (memory holds 77), followed by an aux read of 1_0010 (memory holds 99).
  - Required: `vdp_rdata[7:0]` = 77 and unchanged through the aux cycle, `aux_rdata` = 99.
